sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO. Successor to the team's dual-clock pointer/counter FIFO for same-domain buffering. Adds:
- reset
- almost-full and almost-empty watermarks
- sticky overflow and underflow error flags
- a read-valid strobe
- an optional first-word-fall-through mode
Sits between producer and consumer stages in one clock domain.

Parameters:
- Width, 8, data word width in bits (>=1).
- Depth_Size, 4, log2 of entry count; Depth = 1<<Depth_Size (>=1).
- AF_Level, 12, fifo_almost_full asserts when occupancy >= AF_Level (1..Depth).
- AE_Level, 2, fifo_almost_empty asserts when occupancy <= AE_Level (0..Depth-1).

Ports:
- Clk  in  1  single clock, all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- fifo_in  in  Width  write data.
- rd_en  in  1  read request (pop).
- clr_err  in  1  synchronous clear of overflow/underflow.
- fifo_out  out  Width  read data.
- fifo_out_valid  out  1  fifo_out holds a newly popped word (standard mode) / head word present (FWFT).
- fifo_full  out  1  occupancy == Depth.
- fifo_empty  out  1  occupancy == 0.
- fifo_almost_full  out  1  occupancy >= AF_Level.
- fifo_almost_empty  out  1  occupancy <= AE_Level.
- fifo_counter  out  Depth_Size+1  current occupancy, 0..Depth.
- overflow  out  1  sticky: write attempted while full and not relieved by a same-cycle read.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count = 0; fifo_out = 0; fifo_out_valid = 0; overflow, underflow = 0.
  - Hence fifo_empty = 1, fifo_almost_empty = 1, fifo_full = 0, fifo_almost_full = 0.
  - Memory contents are not cleared. Reset mid-operation discards all queued data immediately; the first write after release lands at entry 0.
- State:
  - wr_ptr and rd_ptr are Depth_Size bits and wrap naturally at Depth (Depth-1 -> 0).
  - count is Depth_Size+1 bits.
  - All flags are combinational decodes of the count register, so they reflect accepted operations one cycle after the edge.
- Read accept: rd_acc = rd_en & !fifo_empty.
- Write accept: wr_acc = wr_en & (!fifo_full | rd_acc).
  - When full, a simultaneous accepted read frees the slot, so both are accepted and count is unchanged.
- When empty with wr_en and rd_en together, only the write is accepted and underflow is set.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Write: mem[wr_ptr] <= fifo_in; wr_ptr increments.
- Read, standard mode:
  - fifo_out <= mem[rd_ptr] on rd_acc; rd_ptr increments; latency 1 cycle.
  - fifo_out_valid is 1 for exactly the cycle after each rd_acc, else 0.
  - fifo_out holds its last value when no read occurs.
- Errors:
  - overflow <= 1 when wr_en & !wr_acc.
  - underflow <= 1 when rd_en & !rd_acc.
  - clr_err clears both; if an error event occurs in the same cycle as clr_err, set wins.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - fifo_out = mem[rd_ptr] combinationally; fifo_out_valid = !fifo_empty.
  - rd_en acknowledges and pops the displayed word.
  - A word written into an empty FIFO appears on fifo_out the cycle after its write edge.
  - The registered fifo_out and its reset value are absent.
  - Flag, counter and error rules are unchanged.
- Undefined: standard registered-read mode as above.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2-style depth helper;
  - constant definitions for pointer width (Depth_Size) and count width (Depth_Size+1);
  - local parameter checks for AF_Level/AE_Level ranges.
- Sub-module fifo_mem_sp: Width x Depth register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). The top owns pointers, count, flags and the output register.

Test Plan:
1. Reset then write 0x11..0x1F, 0x20 (16 writes, defaults) -> fifo_full=1, fifo_counter=16, fifo_almost_full high from count 12, overflow stays 0.
2. Full FIFO; assert wr_en=1, rd_en=1 with fifo_in=0xAA -> count stays 16, fifo_out=0x11 next cycle with fifo_out_valid=1, 0xAA later read as 17th word in order.
3. Empty FIFO; rd_en=1 alone -> underflow=1, fifo_out unchanged, count 0; clr_err=1 one cycle -> underflow=0.
4. Write 20 words continuously into empty FIFO with no reads -> first 16 accepted, overflow=1 at cycle 17, reading back yields exactly first 16 values in order.
5. Wrap: 3 rounds of write 10 / read 10 -> pointers wrap, all 30 values read back in order, fifo_almost_empty toggles at count 2/3.
6. Mid-stream Rst_n low for 1 ns between edges with count=7 -> fifo_empty=1, fifo_counter=0 immediately; with SYNC_FIFO_FWFT_EN: after next write 0x5A, fifo_out=0x5A and fifo_out_valid=1 without rd_en.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared sizing helpers, defaults and configuration checks for the
//   single-clock flagged FIFO (sync_fifo_flags) and its storage array
//   (fifo_mem_sp).
//   Contents:
//     DEF_*            default parameter values
//     depth_of()       entry count from log2 depth
//     clog2_depth()    ceil(log2(n)) helper
//     ptr_width()      read/write pointer width
//     cnt_width()      occupancy counter width (one extra bit to hold Depth)
//     *_level_ok()     legal ranges for the watermark levels
//     fifo_flags_t     decoded status flags
package sync_fifo_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH_SIZE = 4;
  localparam int DEF_AF_LEVEL   = 12;
  localparam int DEF_AE_LEVEL   = 2;

  function automatic int depth_of(input int depth_size);
    return 1 << depth_size;
  endfunction

  function automatic int clog2_depth(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ptr_width(input int depth_size);
    return depth_size;
  endfunction

  // Occupancy must represent 0..Depth inclusive, so one bit wider than a pointer.
  function automatic int cnt_width(input int depth_size);
    return depth_size + 1;
  endfunction

  function automatic bit af_level_ok(input int depth_size, input int af_level);
    return (af_level >= 1) && (af_level <= depth_of(depth_size));
  endfunction

  function automatic bit ae_level_ok(input int depth_size, input int ae_level);
    return (ae_level >= 0) && (ae_level <= depth_of(depth_size) - 1);
  endfunction

  function automatic bit cfg_ok(input int width, input int depth_size,
                                input int af_level, input int ae_level);
    return (width >= 1) && (depth_size >= 1) &&
           (clog2_depth(depth_of(depth_size)) == depth_size) &&
           af_level_ok(depth_size, af_level) &&
           ae_level_ok(depth_size, ae_level);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_mem_sp.sv
// fifo_mem_sp
//   Width x (1<<Depth_Size) register array backing the FIFO.
//   Synchronous write, asynchronous (combinational) read. Contents are
//   never reset; the FIFO pointers decide which entries are meaningful.
//   Ports:
//     clk    in   write clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  read data (combinational from raddr)
module fifo_mem_sp
  import sync_fifo_pkg::*;
#(
  parameter int Width      = DEF_WIDTH,
  parameter int Depth_Size = DEF_DEPTH_SIZE
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [Depth_Size-1:0] waddr,
  input  logic [Width-1:0]      wdata,
  input  logic [Depth_Size-1:0] raddr,
  output logic [Width-1:0]      rdata
);

  localparam int Depth = depth_of(Depth_Size);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with full/empty, almost-full/almost-empty watermarks,
//   sticky overflow/underflow flags and a read-valid strobe.
//   Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through: the
//   head word is shown combinationally on fifo_out and rd_en pops it.
//   Without the macro, fifo_out is registered and updated one cycle after
//   an accepted read.
//   Ports:
//     Clk, Rst_n          clock, asynchronous active-low reset
//     wr_en, fifo_in      write request and data
//     rd_en               read (pop) request
//     clr_err             synchronous clear of overflow/underflow
//     fifo_out            read data
//     fifo_out_valid      popped-word strobe (std) / head present (FWFT)
//     fifo_full/empty     occupancy == Depth / == 0
//     fifo_almost_full    occupancy >= AF_Level
//     fifo_almost_empty   occupancy <= AE_Level
//     fifo_counter        occupancy 0..Depth
//     overflow/underflow  sticky error flags
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int Width      = DEF_WIDTH,
  parameter int Depth_Size = DEF_DEPTH_SIZE,
  parameter int AF_Level   = DEF_AF_LEVEL,
  parameter int AE_Level   = DEF_AE_LEVEL
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  wr_en,
  input  logic [Width-1:0]      fifo_in,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [Width-1:0]      fifo_out,
  output logic                  fifo_out_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [Depth_Size:0]   fifo_counter,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int Depth = depth_of(Depth_Size);
  localparam int PTR_W = ptr_width(Depth_Size);
  localparam int CNT_W = cnt_width(Depth_Size);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(Depth);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_Level);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_Level);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  if (!cfg_ok(Width, Depth_Size, AF_Level, AE_Level)) begin : g_bad_cfg
    $error("sync_fifo_flags: illegal Width/Depth_Size/AF_Level/AE_Level");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_acc, wr_acc;
  logic [Width-1:0] mem_rdata;
  fifo_flags_t      flags;

  // Flags decode the registered count only, so they lag accepted
  // operations by one edge and never depend on this cycle's requests.
  always_comb begin
    flags        = '0;
    flags.full   = (count_q == DEPTH_C);
    flags.empty  = (count_q == '0);
    flags.afull  = (count_q >= AF_C);
    flags.aempty = (count_q <= AE_C);
  end

  // A read from a full FIFO frees the slot the write needs this same edge.
  assign rd_acc = rd_en & ~flags.empty;
  assign wr_acc = wr_en & (~flags.full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Sticky errors; a new event in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_acc);
    udf_d = (udf_q & ~clr_err) | (rd_en & ~rd_acc);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_sp #(
    .Width      (Width),
    .Depth_Size (Depth_Size)
  ) u_mem (
    .clk   (Clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (fifo_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is always on the read port; a word written into an empty
  // FIFO shows up once count leaves zero after its write edge.
  assign fifo_out       = mem_rdata;
  assign fifo_out_valid = ~flags.empty;
`else
  logic [Width-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;

  // Output register holds the last popped word between reads; the valid
  // strobe marks only the cycle right after each accepted read.
  always_comb begin
    dout_d = dout_q;
    vld_d  = rd_acc;
    if (rd_acc) dout_d = mem_rdata;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign fifo_out       = dout_q;
  assign fifo_out_valid = vld_q;
`endif

  assign fifo_full         = flags.full;
  assign fifo_empty        = flags.empty;
  assign fifo_almost_full  = flags.afull;
  assign fifo_almost_empty = flags.aempty;
  assign fifo_counter      = count_q;
  assign overflow          = ovf_q;
  assign underflow         = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags
//   Directed scenarios plus randomized traffic against a queue-based
//   reference model of the FIFO rules. Honors SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_flags;

  localparam int W     = 8;
  localparam int DS    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  fifo_in = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  fifo_out;
  logic          fifo_out_valid;
  logic          fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic [DS:0]   fifo_counter;
  logic          overflow, underflow;

  sync_fifo_flags #(
    .Width(W), .Depth_Size(DS), .AF_Level(AF), .AE_Level(AE)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .wr_en(wr_en), .fifo_in(fifo_in),
    .rd_en(rd_en), .clr_err(clr_err), .fifo_out(fifo_out),
    .fifo_out_valid(fifo_out_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full),
    .fifo_almost_empty(fifo_almost_empty), .fifo_counter(fifo_counter),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 Clk = ~Clk;

  // Reference model
  logic [W-1:0] mq[$];
  logic [W-1:0] m_out;
  bit           m_vld, m_ov, m_un;
  int           n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = '0;
    m_vld = 1'b0;
    m_ov  = 1'b0;
    m_un  = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count",  32'(fifo_counter),      32'(n));
    chk("full",   32'(fifo_full),         32'(n == DEPTH));
    chk("empty",  32'(fifo_empty),        32'(n == 0));
    chk("afull",  32'(fifo_almost_full),  32'(n >= AF));
    chk("aempty", 32'(fifo_almost_empty), 32'(n <= AE));
    chk("ovf",    32'(overflow),          32'(m_ov));
    chk("udf",    32'(underflow),         32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
    chk("valid",  32'(fifo_out_valid),    32'(n != 0));
    if (n != 0) chk("out", 32'(fifo_out), 32'(mq[0]));
`else
    chk("valid",  32'(fifo_out_valid),    32'(m_vld));
    chk("out",    32'(fifo_out),          32'(m_out));
`endif
  endtask

  // Apply one cycle of requests, advance the model by the FIFO rules, check.
  task automatic cycle(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    bit racc, wacc;
    int n;
    wr_en = w; fifo_in = d; rd_en = r; clr_err = c;
    @(posedge Clk);
    n    = mq.size();
    racc = r && (n != 0);
    wacc = w && ((n != DEPTH) || racc);
    m_vld = racc;
    if (racc) m_out = mq.pop_front();
    if (wacc) mq.push_back(d);
    if (c) begin m_ov = 1'b0; m_un = 1'b0; end
    if (w && !wacc) m_ov = 1'b1;
    if (r && !racc) m_un = 1'b1;
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i <= DEPTH && mq.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int wp, rp;
    n_chk = 0; n_fail = 0;
    model_reset();

    // Reset state
    #12;
    check_all();
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_out", 32'(fifo_out), 32'h0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;

    // Fill: 0x11..0x20
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(8'h11 + i), 1'b0, 1'b0);
    // Write+read while full
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    drain();
    // Underflow on empty, then clear
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    // Overrun: 20 writes, read back
    for (int i = 0; i < 20; i++) cycle(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1);
    // Pointer wrap: 3 x (10 writes, 10 reads)
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, W'(8'h80 + 10*k + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    end
    // Empty with simultaneous write and read
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic in phases of different write/read bias
    for (int ph = 0; ph < 8; ph++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 300; i++)
        cycle($urandom_range(0, 99) < wp, W'($urandom), $urandom_range(0, 99) < rp,
              $urandom_range(0, 31) == 0);
    end

    // Mid-stream asynchronous reset with 7 words queued
    drain();
    for (int i = 0; i < 7; i++) cycle(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(fifo_empty),   32'h1);
    chk("arst_count", 32'(fifo_counter), 32'h0);
    Rst_n = 1'b1;
    model_reset();
    check_all();
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
